// File: rtl/scroll_pattern_gen.sv
//------------------------------------------------------------------------------
// scroll_pattern_gen
//
// Sits between the hvsync_generator outputs and the rgb pins. A programmable
// clock divider emits a one-cycle tick that advances a free-running scroll
// phase. At each frame boundary the phase and the requested display mode are
// latched, so the picture never tears mid-frame. The registered rgb output
// shows one of four scrolling patterns built from those latched values.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   display_on   visible-area flag from hvsync_generator
//   hpos, vpos   current pixel / line position (COORD_W bits)
//   frame_start  one-cycle pulse at the frame boundary; latches phase and mode
//   mode         pattern select: 0 solid, 1 h-stripes, 2 v-stripes, 3 checker
//   pause        freezes the divider and the phase accumulator
//   tick_out     one-cycle pulse every DIVISOR unpaused cycles
//   phase        frame-latched scroll phase (PHASE_W bits)
//   rgb          registered {b,g,r} pixel colour
//------------------------------------------------------------------------------
module scroll_pattern_gen #(
   parameter int         COORD_W    = 9,
   parameter int         DIVISOR    = 511,
   parameter int         PHASE_W    = 9,
   parameter int         STEP       = 1,
   parameter int         STRIPE_BIT = 1,
   parameter logic [2:0] COLOR0     = 3'b101,
   parameter logic [2:0] COLOR1     = 3'b111
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               display_on,
   input  logic [COORD_W-1:0] hpos,
   input  logic [COORD_W-1:0] vpos,
   input  logic               frame_start,
   input  logic [1:0]         mode,
   input  logic               pause,
   output logic               tick_out,
   output logic [PHASE_W-1:0] phase,
   output logic [2:0]         rgb
);

   localparam int                 DIV_W       = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(DIVISOR - 1);
   localparam logic [PHASE_W-1:0] STEP_INC    = PHASE_W'(STEP);
   localparam int                 SUM_W       = (COORD_W > PHASE_W) ? COORD_W : PHASE_W;
   localparam logic [SUM_W-1:0]   STRIPE_MASK = SUM_W'(1) << STRIPE_BIT;

   logic [DIV_W-1:0]   div_cnt;
   logic [PHASE_W-1:0] phase_live;
   logic [1:0]         mode_q;
   logic [SUM_W-1:0]   h_sum;
   logic [SUM_W-1:0]   v_sum;
   logic               h_bit;
   logic               v_bit;
   logic               p;

   // Divider and phase accumulator. Pause holds the count where it is so
   // the tick cadence resumes without losing or doubling a tick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt    <= '0;
         tick_out   <= 1'b0;
         phase_live <= '0;
      end else if (pause) begin
         tick_out <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt    <= '0;
         tick_out   <= 1'b1;
         phase_live <= phase_live + STEP_INC;
      end else begin
         div_cnt  <= div_cnt + DIV_W'(1);
         tick_out <= 1'b0;
      end
   end

   // Frame latch. Uses the pre-increment phase_live when a tick lands on the
   // same edge; the increment shows up at the following frame boundary.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase  <= '0;
         mode_q <= 2'd0;
      end else if (frame_start) begin
         phase  <= phase_live;
         mode_q <= mode;
      end
   end

   // Sums wrap at the wider of the coordinate and phase widths. The stripe
   // bit is pulled out with a mask so every sum bit takes part in the logic.
   assign h_sum = SUM_W'(hpos) + SUM_W'(phase);
   assign v_sum = SUM_W'(vpos) + SUM_W'(phase);
   assign h_bit = |(h_sum & STRIPE_MASK);
   assign v_bit = |(v_sum & STRIPE_MASK);

   // Pattern bit selection from the frame-latched mode.
   always_comb begin
      p = 1'b0;
      case (mode_q)
         2'd0:    p = 1'b0;
         2'd1:    p = v_bit;
         2'd2:    p = h_bit;
         default: p = h_bit ^ vpos[STRIPE_BIT];
      endcase
   end

   // Registered colour output, blanked outside the visible area.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rgb <= 3'b000;
      end else begin
         rgb <= display_on ? (p ? COLOR1 : COLOR0) : 3'b000;
      end
   end

endmodule

// File: tb/tb_scroll_pattern_gen.sv
//------------------------------------------------------------------------------
// tb_scroll_pattern_gen
//
// Self-checking bench for scroll_pattern_gen. A DIVISOR=4 / STEP=1 instance
// covers divider period, pause, frame-latch collision and pattern modes; a
// DIVISOR=4 / STEP=3 instance on the same stimulus covers phase wrap. Pixel
// expectations are queued when stimulus is driven and popped when rgb is due.
//------------------------------------------------------------------------------
module tb_scroll_pattern_gen;

   logic       clk;
   logic       reset;
   logic       display_on;
   logic [8:0] hpos;
   logic [8:0] vpos;
   logic       frame_start;
   logic [1:0] mode;
   logic       pause;

   logic       tick_out;
   logic [8:0] phase;
   logic [2:0] rgb;
   logic       w_tick_out;
   logic [8:0] w_phase;
   logic [2:0] w_rgb;

   int test_count;
   int fail_count;

   typedef struct {
      logic       latch;
      logic [1:0] mode_sel;
      logic       de;
      logic [8:0] h;
      logic [8:0] v;
      logic [2:0] exp_rgb;
   } vec_t;

   vec_t       vecs[10];
   logic [2:0] exp_q[$];

   scroll_pattern_gen #(
      .COORD_W(9), .DIVISOR(4), .PHASE_W(9), .STEP(1), .STRIPE_BIT(1),
      .COLOR0(3'b101), .COLOR1(3'b111)
   ) dut (
      .clk(clk), .reset(reset), .display_on(display_on), .hpos(hpos),
      .vpos(vpos), .frame_start(frame_start), .mode(mode), .pause(pause),
      .tick_out(tick_out), .phase(phase), .rgb(rgb)
   );

   scroll_pattern_gen #(
      .COORD_W(9), .DIVISOR(4), .PHASE_W(9), .STEP(3), .STRIPE_BIT(1),
      .COLOR0(3'b101), .COLOR1(3'b111)
   ) dut_wrap (
      .clk(clk), .reset(reset), .display_on(display_on), .hpos(hpos),
      .vpos(vpos), .frame_start(frame_start), .mode(mode), .pause(pause),
      .tick_out(w_tick_out), .phase(w_phase), .rgb(w_rgb)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just past it.
   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      test_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Hold reset for two edges, then release so the next edge is edge 1.
   task automatic reset_dut(input logic hold_pause);
      reset       = 1'b0;
      frame_start = 1'b0;
      pause       = hold_pause;
      display_on  = 1'b0;
      hpos        = '0;
      vpos        = '0;
      mode        = 2'd0;
      step_clk();
      step_clk();
      reset = 1'b1;
   endtask

   // Optional frame latch, then drive one pixel and compare one cycle later.
   task automatic applyStimulus(input vec_t v, input string name);
      logic [2:0] exp_val;
      mode = v.mode_sel;
      if (v.latch) begin
         frame_start = 1'b1;
         step_clk();
         frame_start = 1'b0;
      end
      display_on = v.de;
      hpos       = v.h;
      vpos       = v.v;
      exp_q.push_back(v.exp_rgb);
      step_clk();
      if (exp_q.size() == 0) begin
         checkOutput({name, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
         exp_val = exp_q.pop_front();
         checkOutput(name, {29'd0, rgb}, {29'd0, exp_val});
      end
   endtask

   initial begin
      logic [2:0] exp_val;
      test_count = 0;
      fail_count = 0;

      // latch, mode, display_on, hpos, vpos, expected rgb (phase 0, bit 1)
      vecs[0] = '{1'b1, 2'd1, 1'b1, 9'd0, 9'd2, 3'b111};
      vecs[1] = '{1'b0, 2'd1, 1'b1, 9'd0, 9'd1, 3'b101};
      vecs[2] = '{1'b1, 2'd3, 1'b1, 9'd2, 9'd2, 3'b101};
      vecs[3] = '{1'b0, 2'd3, 1'b1, 9'd2, 9'd0, 3'b111};
      vecs[4] = '{1'b0, 2'd3, 1'b0, 9'd2, 9'd0, 3'b000};
      vecs[5] = '{1'b1, 2'd0, 1'b1, 9'd3, 9'd3, 3'b101};
      vecs[6] = '{1'b1, 2'd2, 1'b1, 9'd6, 9'd0, 3'b111};
      vecs[7] = '{1'b0, 2'd2, 1'b1, 9'd5, 9'd0, 3'b101};
      vecs[8] = '{1'b0, 2'd1, 1'b1, 9'd2, 9'd0, 3'b111};
      vecs[9] = '{1'b1, 2'd1, 1'b1, 9'd0, 9'd3, 3'b111};

      // Reset state
      reset_dut(1'b0);
      reset = 1'b0;
      checkOutput("reset_rgb", {29'd0, rgb}, 32'd0);
      checkOutput("reset_tick", {31'd0, tick_out}, 32'd0);
      checkOutput("reset_phase", {23'd0, phase}, 32'd0);

      // Divider period: ticks after edges 4, 8, 12, phase_live 3 by edge 12
      reset_dut(1'b0);
      for (int k = 1; k <= 12; k++) begin
         step_clk();
         checkOutput($sformatf("div_tick_e%0d", k), {31'd0, tick_out},
                     {31'd0, (k % 4 == 0)});
      end
      frame_start = 1'b1;
      step_clk();
      frame_start = 1'b0;
      checkOutput("div_phase_after_12", {23'd0, phase}, 32'd3);
      checkOutput("div_tick_e13", {31'd0, tick_out}, 32'd0);

      // Pause from div_cnt=2 for 10 edges, frame latch honoured while paused
      reset_dut(1'b0);
      step_clk();
      step_clk();
      pause = 1'b1;
      for (int k = 0; k < 10; k++) begin
         frame_start = (k == 5);
         step_clk();
         checkOutput($sformatf("pause_no_tick_%0d", k), {31'd0, tick_out}, 32'd0);
      end
      frame_start = 1'b0;
      checkOutput("pause_phase_held", {23'd0, phase}, 32'd0);
      pause = 1'b0;
      step_clk();
      checkOutput("pause_resume_e1", {31'd0, tick_out}, 32'd0);
      step_clk();
      checkOutput("pause_resume_e2", {31'd0, tick_out}, 32'd1);
      frame_start = 1'b1;
      step_clk();
      frame_start = 1'b0;
      checkOutput("pause_phase_after", {23'd0, phase}, 32'd1);

      // Frame latch colliding with the tick that takes phase_live 5 -> 6
      reset_dut(1'b0);
      repeat (23) step_clk();
      frame_start = 1'b1;
      step_clk();
      frame_start = 1'b0;
      checkOutput("collide_tick", {31'd0, tick_out}, 32'd1);
      checkOutput("collide_phase", {23'd0, phase}, 32'd5);
      frame_start = 1'b1;
      step_clk();
      frame_start = 1'b0;
      checkOutput("collide_next_phase", {23'd0, phase}, 32'd6);

      // Pattern table, phase held at 0 by pause
      reset_dut(1'b1);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i], $sformatf("pattern_v%0d", i));
      end
      pause = 1'b0;

      // Wrap on the STEP=3 instance: 170 ticks reach 510, one more gives 1
      reset_dut(1'b0);
      repeat (680) step_clk();
      mode        = 2'd2;
      frame_start = 1'b1;
      step_clk();
      frame_start = 1'b0;
      checkOutput("wrap_phase_510", {23'd0, w_phase}, 32'd510);
      repeat (3) step_clk();
      checkOutput("wrap_tick", {31'd0, w_tick_out}, 32'd1);
      frame_start = 1'b1;
      step_clk();
      frame_start = 1'b0;
      checkOutput("wrap_phase_1", {23'd0, w_phase}, 32'd1);
      display_on = 1'b1;
      hpos       = 9'd0;
      vpos       = 9'd0;
      exp_q.push_back(3'b101);
      step_clk();
      exp_val = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
      checkOutput("wrap_rgb_h0", {29'd0, w_rgb}, {29'd0, exp_val});
      hpos = 9'd1;
      exp_q.push_back(3'b111);
      step_clk();
      exp_val = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
      checkOutput("wrap_rgb_h1", {29'd0, w_rgb}, {29'd0, exp_val});

      // Asynchronous reset between edges while w_rgb is 3'b111
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_rgb", {29'd0, w_rgb}, 32'd0);
      checkOutput("async_tick", {31'd0, w_tick_out}, 32'd0);
      checkOutput("async_phase", {23'd0, w_phase}, 32'd0);
      checkOutput("async_main_phase", {23'd0, phase}, 32'd0);
      step_clk();
      reset = 1'b1;

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule

// File: doc/scroll_pattern_gen.md
Name: scroll_pattern_gen

Overview:
- Parametrised successor to the top-level divider-plus-stripe colour logic.
- Sits between hvsync_generator outputs (display_on, hpos, vpos) and the rgb pins.
- Contains a programmable clock divider that produces a one-cycle tick. The tick advances a scroll phase.
- The phase and display mode are latched once per frame so the picture never tears. The block then drives registered rgb from one of four scrolling stripe/checker patterns.

Parameters:
- COORD_W, 9: width of hpos/vpos.
- DIVISOR, 511: tick period in clk cycles. Legal range 2..2^16.
- PHASE_W, 9: width of scroll phase accumulator.
- STEP, 1: phase increment per tick, taken modulo 2^PHASE_W.
- STRIPE_BIT, 1: coordinate bit that selects stripe colour. Must be less than min(COORD_W, PHASE_W).
- COLOR0, 3'b101: rgb {b,g,r} when the pattern bit is 0 (pink).
- COLOR1, 3'b111: rgb when the pattern bit is 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- display_on  in  1  visible-area flag from hvsync_generator.
- hpos  in  COORD_W  horizontal pixel position.
- vpos  in  COORD_W  vertical line position.
- frame_start  in  1  one-cycle pulse at frame boundary; latches phase and mode.
- mode  in  2  pattern select: 0 solid, 1 horizontal stripes, 2 vertical stripes, 3 checker.
- pause  in  1  freezes divider and phase accumulation.
- tick_out  out  1  one-cycle pulse every DIVISOR unpaused cycles.
- phase  out  PHASE_W  frame-latched scroll phase.
- rgb  out  3  {b,g,r} pixel colour.

Behaviour:
- Reset (reset low, asynchronous) clears div_cnt, tick_out, phase_live, phase, mode_q and rgb to 0.
- Release of reset is synchronous to clk.
- Divider: div_cnt has width clog2(DIVISOR) and counts 0..DIVISOR-1.
  - At an edge with pause=0: if div_cnt==DIVISOR-1, div_cnt<=0, tick_out<=1, and phase_live<=phase_live+STEP (truncated to PHASE_W).
  - Otherwise at that edge div_cnt<=div_cnt+1 and tick_out<=0.
  - First tick_out is high in the cycle following the DIVISOR-th edge after reset release.
- pause=1: div_cnt and phase_live hold, and tick_out<=0. Counting resumes from the held value; no tick is lost or duplicated.
- Frame latch: at an edge with frame_start=1, phase<=phase_live and mode_q<=mode.
  - If a tick occurs on the same edge, phase captures the pre-increment phase_live.
  - The increment then appears at the next frame_start.
  - frame_start is honoured regardless of pause.
- Pattern bit p is combinational from current inputs and latched state:
  - mode_q 0: p=0.
  - mode_q 1: p=(vpos+phase)[STRIPE_BIT].
  - mode_q 2: p=(hpos+phase)[STRIPE_BIT].
  - mode_q 3: p=(hpos+phase)[STRIPE_BIT] XOR vpos[STRIPE_BIT].
  - Sums are computed at max(COORD_W, PHASE_W) bits and wrap modulo that width.
- Output: rgb<=display_on ? (p ? COLOR1 : COLOR0) : 3'b000, registered.
  - Latency is exactly 1 clk from display_on/hpos/vpos to rgb.
- Changes to the mode input between frame_start pulses have no visible effect.
- Phase wrap: after 2^PHASE_W/gcd(STEP, 2^PHASE_W) ticks, phase_live returns to 0 seamlessly.
- Reset asserted mid-frame forces rgb=0 immediately (asynchronously). Patterns restart in mode 0 with phase 0.

Test Plan:
- Divider period: DIVISOR=4, pause=0, reset released at edge 0.
  - Required: tick_out high after edges 4, 8 and 12, each for exactly 1 cycle.
  - Required: phase_live reaches 3 after 12 edges.
- Pause: DIVISOR=4, pause=1 for 10 cycles starting at div_cnt=2.
  - Required: no tick during the pause.
  - Required: the next tick arrives 2 edges after pause drops.
  - Required: phase_live is unchanged across the pause.
- Frame latch collision: frame_start and a tick on the same edge with phase_live=5, STEP=1.
  - Required: phase=5 and phase_live=6.
  - Required: the next frame_start gives phase=6.
- Pattern modes with STRIPE_BIT=1, phase=0, display_on=1:
  - mode 1 latched, vpos=2: rgb=3'b111 one cycle later; vpos=1: rgb=3'b101.
  - mode 3, hpos=2, vpos=2: rgb=3'b101.
  - display_on=0: rgb=3'b000.
- Wrap: PHASE_W=9, STEP=3, phase_live=510, one tick.
  - Required: phase_live=1.
  - Then mode 2, frame latch, hpos=0: p=(0+1)[1]=0, so rgb=3'b101.
- Async reset: assert reset low between clk edges while rgb=3'b111.
  - Required: rgb=0, tick_out=0 and phase=0 immediately, without waiting for a clock edge.
